// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: port indices,
// priority-pointer encoding and the address-width helper.
package mem_arb_pkg;

  localparam int NUM_PORTS = 2;
  localparam int PORT0     = 0;
  localparam int PORT1     = 1;

  typedef enum logic {
    PRI0 = 1'b0,
    PRI1 = 1'b1
  } pri_e;

  // Bits needed to index a memory of the given depth (at least one).
  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/mem_arb_rsp_slot.sv
// One-entry response holding register: load has priority over clear, so a
// consume and a new grant in the same cycle reload without a bubble.
module mem_arb_rsp_slot #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [WIDTH-1:0] load_rdata,
  input  logic             load_err,
  output logic             valid,
  output logic [WIDTH-1:0] rdata,
  output logic             err
);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      rdata <= load_rdata;
      err   <= load_err;
    end else if (clear) begin
      valid <= 1'b0;
      rdata <= '0;
      err   <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory, one grant per cycle.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin; default build is fixed priority (port 0).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_addr,
  input  logic             req0_we,
  input  logic [WIDTH-1:0] req0_wdata,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_rdata,
  output logic             rsp0_err,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_addr,
  input  logic             req1_we,
  input  logic [WIDTH-1:0] req1_wdata,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_rdata,
  output logic             rsp1_err,
  output logic [WIDTH-1:0] mem_address,
  output logic [WIDTH-1:0] mem_data_write,
  output logic             mem_MemWrite,
  output logic             mem_MemRead,
  input  logic [WIDTH-1:0] mem_data_read
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam logic [ADDR_W:0] DEPTH_A = (ADDR_W + 1)'(DEPTH);

  logic [NUM_PORTS-1:0] req_v, rsp_r, rsp_v, in_range, elig, cand, grant;
  logic                 favour0;

  assign req_v = {req1_valid, req0_valid};
  assign rsp_r = {rsp1_ready, rsp0_ready};
  assign rsp_v = {rsp1_valid, rsp0_valid};

  // Upper address bits must be zero and the low bits below DEPTH, which also
  // covers depths that are not a power of two.
  assign in_range[PORT0] = (req0_addr[WIDTH-1:ADDR_W] == '0) &&
                           ({1'b0, req0_addr[ADDR_W-1:0]} < DEPTH_A);
  assign in_range[PORT1] = (req1_addr[WIDTH-1:ADDR_W] == '0) &&
                           ({1'b0, req1_addr[ADDR_W-1:0]} < DEPTH_A);

  assign elig = ~rsp_v | rsp_r;
  assign cand = req_v & elig & {NUM_PORTS{~rst}};

`ifdef MEM_ARB_ROUND_ROBIN_EN
  pri_e pri_q, pri_d;

  always_ff @(posedge clk) begin
    if (rst) pri_q <= PRI0;
    else     pri_q <= pri_d;
  end

  // After contention the pointer moves to the port that lost.
  always_comb begin
    pri_d = pri_q;
    if (&cand) pri_d = (pri_q == PRI0) ? PRI1 : PRI0;
  end

  assign favour0 = (pri_q == PRI0);
`else
  assign favour0 = 1'b1;
`endif

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    grant = '0;
    if (cand[PORT0] && (!cand[PORT1] || favour0)) grant[PORT0] = 1'b1;
    else if (cand[PORT1])                         grant[PORT1] = 1'b1;
  end

  assign req0_ready = elig[PORT0] & ~rst & ~grant[PORT1];
  assign req1_ready = elig[PORT1] & ~rst & ~grant[PORT0];

  logic             any_grant, g_we, g_in_range;
  logic [WIDTH-1:0] g_addr, g_wdata;

  assign any_grant  = |grant;
  assign g_addr     = grant[PORT1] ? req1_addr  : req0_addr;
  assign g_wdata    = grant[PORT1] ? req1_wdata : req0_wdata;
  assign g_we       = grant[PORT1] ? req1_we    : req0_we;
  assign g_in_range = grant[PORT1] ? in_range[PORT1] : in_range[PORT0];

  assign mem_MemWrite   = any_grant &  g_we & g_in_range;
  assign mem_MemRead    = any_grant & ~g_we & g_in_range;
  assign mem_address    = (any_grant && g_in_range) ? g_addr : '0;
  assign mem_data_write = mem_MemWrite ? g_wdata : '0;

  logic [WIDTH-1:0] ld_rdata;
  assign ld_rdata = mem_MemRead ? mem_data_read : '0;

  mem_arb_rsp_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk        (clk),
    .rst        (rst),
    .load       (grant[PORT0]),
    .clear      (rsp0_ready),
    .load_rdata (ld_rdata),
    .load_err   (~g_in_range),
    .valid      (rsp0_valid),
    .rdata      (rsp0_rdata),
    .err        (rsp0_err)
  );

  mem_arb_rsp_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk        (clk),
    .rst        (rst),
    .load       (grant[PORT1]),
    .clear      (rsp1_ready),
    .load_rdata (ld_rdata),
    .load_err   (~g_in_range),
    .valid      (rsp1_valid),
    .rdata      (rsp1_rdata),
    .err        (rsp1_err)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios then random traffic,
// compared against a transaction-level model of grants, slots and memory.
module tb_mem_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 1024;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic             clk, rst;
  logic             req0_valid, req0_ready, req0_we, rsp0_valid, rsp0_ready, rsp0_err;
  logic             req1_valid, req1_ready, req1_we, rsp1_valid, rsp1_ready, rsp1_err;
  logic [WIDTH-1:0] req0_addr, req0_wdata, rsp0_rdata;
  logic [WIDTH-1:0] req1_addr, req1_wdata, rsp1_rdata;
  logic [WIDTH-1:0] mem_address, mem_data_write, mem_data_read;
  logic             mem_MemWrite, mem_MemRead;

  mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_we(req0_we), .req0_wdata(req0_wdata),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_we(req1_we), .req1_wdata(req1_wdata),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .mem_address(mem_address), .mem_data_write(mem_data_write),
    .mem_MemWrite(mem_MemWrite), .mem_MemRead(mem_MemRead), .mem_data_read(mem_data_read)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Attached data memory: combinational read, write on the rising edge.
  logic [WIDTH-1:0] env_mem [DEPTH];
  assign mem_data_read = (mem_address < DEPTH) ? env_mem[mem_address[9:0]] : '0;
  always @(posedge clk)
    if (mem_MemWrite && mem_address < DEPTH) env_mem[mem_address[9:0]] <= mem_data_write;

  // Reference model state
  logic [WIDTH-1:0] m_mem [DEPTH];
  bit               m_valid [2];
  logic [WIDTH-1:0] m_rdata [2];
  bit               m_err [2];
  bit               m_pri;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at the falling edge, check just after, then advance the
  // model to the state the next rising edge must produce.
  task automatic step(input bit v0, input logic [WIDTH-1:0] a0, input bit we0,
                      input logic [WIDTH-1:0] wd0, input bit rr0,
                      input bit v1, input logic [WIDTH-1:0] a1, input bit we1,
                      input logic [WIDTH-1:0] wd1, input bit rr1, input bit r);
    bit               v [2], we [2], rr [2], cand [2], ok, wr, rd;
    logic [WIDTH-1:0] a [2], wd [2];
    int               win;
    @(negedge clk);
    req0_valid = v0; req0_addr = a0; req0_we = we0; req0_wdata = wd0; rsp0_ready = rr0;
    req1_valid = v1; req1_addr = a1; req1_we = we1; req1_wdata = wd1; rsp1_ready = rr1;
    rst = r;
    #1;
    v = '{v0, v1}; a = '{a0, a1}; we = '{we0, we1}; wd = '{wd0, wd1}; rr = '{rr0, rr1};
    for (int n = 0; n < 2; n++) cand[n] = v[n] && (!m_valid[n] || rr[n]) && !r;
    if (cand[0] && cand[1]) win = (RR_EN && m_pri) ? 1 : 0;
    else if (cand[0])       win = 0;
    else if (cand[1])       win = 1;
    else                    win = -1;

    check("req0_ready", req0_ready, !r && (!m_valid[0] || rr[0]) && win != 1);
    check("req1_ready", req1_ready, !r && (!m_valid[1] || rr[1]) && win != 0);
    check("rsp0_valid", rsp0_valid, m_valid[0]);
    check("rsp0_rdata", rsp0_rdata, m_rdata[0]);
    check("rsp0_err",   rsp0_err,   m_err[0]);
    check("rsp1_valid", rsp1_valid, m_valid[1]);
    check("rsp1_rdata", rsp1_rdata, m_rdata[1]);
    check("rsp1_err",   rsp1_err,   m_err[1]);

    ok = (win >= 0) && (a[win] < DEPTH);
    wr = ok && we[win];
    rd = ok && !we[win];
    check("mem_MemWrite", mem_MemWrite, wr);
    check("mem_MemRead",  mem_MemRead,  rd);
    if (win < 0) check("mem_address_idle", mem_address, '0);
    else if (ok) check("mem_address", mem_address, a[win]);
    if (wr)      check("mem_data_write", mem_data_write, wd[win]);

    if (r) begin
      m_valid = '{0, 0}; m_rdata = '{'0, '0}; m_err = '{0, 0}; m_pri = 1'b0;
    end else begin
      for (int n = 0; n < 2; n++) begin
        if (win == n) begin
          m_valid[n] = 1'b1;
          m_err[n]   = !ok;
          m_rdata[n] = rd ? m_mem[a[n][9:0]] : '0;
        end else if (rr[n]) begin
          m_valid[n] = 1'b0; m_rdata[n] = '0; m_err[n] = 1'b0;
        end
      end
      if (wr) m_mem[a[win][9:0]] = wd[win];
      if (RR_EN && cand[0] && cand[1]) m_pri = (win == 0);
    end
  endtask

  task automatic idle(input bit rr0, input bit rr1);
    step(0, '0, 0, '0, rr0, 0, '0, 0, '0, rr1, 0);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      env_mem[i] = '0;
      m_mem[i]   = '0;
    end
    m_valid = '{0, 0}; m_rdata = '{'0, '0}; m_err = '{0, 0}; m_pri = 1'b0;
    rst = 1'b1;
    req0_valid = 0; req0_addr = '0; req0_we = 0; req0_wdata = '0; rsp0_ready = 0;
    req1_valid = 0; req1_addr = '0; req1_we = 0; req1_wdata = '0; rsp1_ready = 0;
    @(posedge clk);
    @(posedge clk);

    // Reset state, still in reset, then released
    step(0, '0, 0, '0, 0, 0, '0, 0, '0, 0, 1);
    idle(0, 0);

    // Write then read back through the other port
    step(1, 32'd5, 1, 32'hDEADBEEF, 1, 0, '0, 0, '0, 1, 0);
    step(0, '0, 0, '0, 1, 1, 32'd5, 0, '0, 1, 0);
    idle(1, 0);
    check("rd_after_wr_data", rsp1_rdata, 32'hDEADBEEF);
    check("rd_after_wr_err", rsp1_err, 1'b0);
    idle(1, 1);

    // Continuous contention with both responses consumed
    for (int i = 0; i < 6; i++) begin
      step(1, 32'(i), 0, '0, 1, 1, 32'(i + 8), 0, '0, 1, 0);
      check("contend_r0", req0_ready, RR_EN ? (i % 2 == 0) : 1'b1);
      check("contend_r1", req1_ready, RR_EN ? (i % 2 == 1) : 1'b0);
    end
    idle(1, 1);

    // Back-pressure on port 0: slot held, second request stalls
    step(1, 32'd5, 0, '0, 0, 0, '0, 0, '0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 32'd6, 0, '0, 0, 0, '0, 0, '0, 1, 0);
      check("stall_ready", req0_ready, 1'b0);
      check("stall_hold", rsp0_rdata, 32'hDEADBEEF);
    end
    step(1, 32'd6, 0, '0, 1, 0, '0, 0, '0, 1, 0);
    check("stall_release", req0_ready, 1'b1);
    idle(1, 1);

    // Out-of-range write
    step(0, '0, 0, '0, 1, 1, 32'd1024, 1, 32'h55AA55AA, 1, 0);
    check("oor_no_write", mem_MemWrite, 1'b0);
    idle(1, 0);
    check("oor_err", rsp1_err, 1'b1);
    check("oor_rdata", rsp1_rdata, '0);
    idle(1, 1);

    // Reset with both slots full and both ports requesting
    step(1, 32'd5, 0, '0, 0, 1, 32'd5, 0, '0, 0, 0);
    step(1, 32'd5, 0, '0, 0, 1, 32'd5, 0, '0, 0, 0);
    step(1, 32'd3, 1, 32'h1234, 0, 1, 32'd3, 1, 32'h5678, 0, 1);
    check("rst_no_write", mem_MemWrite, 1'b0);
    idle(0, 0);
    check("rst_clears0", rsp0_valid, 1'b0);
    check("rst_clears1", rsp1_valid, 1'b0);
    check("rst_mem_intact", env_mem[3], '0);
    step(1, 32'd4, 0, '0, 0, 1, 32'd4, 0, '0, 0, 0);
    check("rst_ptr_pri0", req0_ready, 1'b1);

    // Consume and re-grant on port 0 in the same cycle
    step(1, 32'd7, 1, 32'hCAFEF00D, 1, 0, '0, 0, '0, 1, 0);
    step(1, 32'd7, 0, '0, 1, 0, '0, 0, '0, 1, 0);
    check("reload_ready", req0_ready, 1'b1);
    idle(0, 1);
    check("reload_valid", rsp0_valid, 1'b1);
    check("reload_data", rsp0_rdata, 32'hCAFEF00D);
    idle(1, 1);

    // Random traffic around the address boundary
    for (int i = 0; i < 400; i++) begin
      logic [WIDTH-1:0] ra0, ra1;
      ra0 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1020, 1030)) : 32'($urandom_range(0, 15));
      ra1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1020, 1030)) : 32'($urandom_range(0, 15));
      step(1'($urandom_range(0, 1)), ra0, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)), ra1, 1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 40) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
